soc_tick_divider: RTL and testbench

// - Multi-channel programmable clock/tick divider. It derives slow square waves and
//   one-cycle tick enables (RTC, fan PWM base, timers) from the SoC clock.
// - Replaces the fixed divide-by-50 RTC generator in the FPGA top level.
// - Every channel has its own runtime-loadable divide ratio. A new ratio takes effect

---
 rtl/soc_tick_divider.sv | 114 +++++++++++
 tb/tb_soc_tick_divider.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_tick_divider.sv
// soc_tick_divider: multi-channel programmable tick/clock divider.
// Each channel derives a square wave and a one-cycle tick from clk_i.
//
// Ports:
//   clk_i        SoC clock
//   rst_ni       async active-low reset
//   en_i         per-channel run enable
//   div_i        per-channel ratio, channel c at [c*CntWidth +: CntWidth]
//   div_valid_i  per-channel ratio update request
//   div_ready_o  per-channel update accept (valid && ready)
//   sync_i       phase-align restart (only with SOC_TICK_DIV_SYNC_EN)
//   clk_o        per-channel divided square wave (registered)
//   tick_o       per-channel pulse in the first high cycle of clk_o
//
// Optional feature macro: SOC_TICK_DIV_SYNC_EN adds sync_i.

module soc_tick_divider #(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned DefaultDiv  = 50
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumChannels-1:0]          en_i,
  input  logic [NumChannels*CntWidth-1:0] div_i,
  input  logic [NumChannels-1:0]          div_valid_i,
  output logic [NumChannels-1:0]          div_ready_o,
`ifdef SOC_TICK_DIV_SYNC_EN
  input  logic                            sync_i,
`endif
  output logic [NumChannels-1:0]          clk_o,
  output logic [NumChannels-1:0]          tick_o
);

  localparam logic [CntWidth-1:0] One    = CntWidth'(1);
  localparam logic [CntWidth-1:0] Two    = CntWidth'(2);
  localparam logic [CntWidth-1:0] DefDiv = CntWidth'(DefaultDiv);

  logic w_sync;

`ifdef SOC_TICK_DIV_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] r_div;
    logic [CntWidth-1:0] r_pdiv;
    logic                r_pend;
    logic                r_clk;
    logic                r_tick;

    logic [CntWidth-1:0] w_d;
    logic [CntWidth-1:0] w_h;
    logic [CntWidth-1:0] w_cnt_nxt;
    logic                w_wrap;
    logic                w_acc;

    // Ratios 0 and 1 cannot form a square wave; run them as 2.
    assign w_d       = (r_div < Two) ? Two : r_div;
    assign w_h       = w_d >> 1;
    assign w_wrap    = (r_cnt == (w_d - One));
    assign w_cnt_nxt = w_wrap ? '0 : (r_cnt + One);
    assign w_acc     = div_valid_i[c] & ~r_pend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt  <= '0;
        r_div  <= DefDiv;
        r_pdiv <= '0;
        r_pend <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (w_sync) begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          if (r_pend) begin
            r_div  <= r_pdiv;
            r_pend <= 1'b0;
          end
        end else if (en_i[c]) begin
          r_cnt  <= w_cnt_nxt;
          // H >= 1, so a wrap to 0 always lands in the low phase.
          r_clk  <= (w_cnt_nxt >= w_h);
          r_tick <= (w_cnt_nxt == w_h);
          if (w_wrap && r_pend) begin
            r_div  <= r_pdiv;
            r_pend <= 1'b0;
          end
        end else if (r_pend) begin
          // Stopped channel: nothing to glitch, restart at once.
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_div  <= r_pdiv;
          r_pend <= 1'b0;
        end
        // Accept only when idle, so it never collides with an apply.
        if (w_acc) begin
          r_pdiv <= div_i[c*CntWidth +: CntWidth];
          r_pend <= 1'b1;
        end
      end
    end

    assign clk_o[c]       = r_clk;
    assign tick_o[c]      = r_tick;
    assign div_ready_o[c] = ~r_pend;
  end

endmodule

// File: tb/tb_soc_tick_divider.sv
// tb_soc_tick_divider: directed bench for soc_tick_divider.
// Period-level model plus literal phase/latency expectations.

module tb_soc_tick_divider;

  localparam int NCH = 2;
  localparam int CW  = 16;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] div;
  logic [NCH-1:0]    div_valid;
  logic [NCH-1:0]    div_ready;
  logic              sync;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;

  int checks;
  int failures;

  soc_tick_divider #(
    .NumChannels(NCH),
    .CntWidth   (CW),
    .DefaultDiv (50)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .div_i      (div),
    .div_valid_i(div_valid),
    .div_ready_o(div_ready),
`ifdef SOC_TICK_DIV_SYNC_EN
    .sync_i     (sync),
`endif
    .clk_o      (clk_out),
    .tick_o     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Model: each channel sits at a position inside a period of
  // P = max(ratio,2) cycles; low for the first P/2 positions.
  int m_pos  [NCH];
  int m_div  [NCH];
  int m_pdiv [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];
  bit m_acc  [NCH];
  bit m_adv  [NCH];
  bit m_sync;

  function automatic int period(int d);
    return (d < 2) ? 2 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_pos[c]  = 0;
        m_div[c]  = 50;
        m_pdiv[c] = 0;
        m_pend[c] = 0;
        m_clk[c]  = 0;
        m_tick[c] = 0;
      end
    end else begin
`ifdef SOC_TICK_DIV_SYNC_EN
      m_sync = sync;
`else
      m_sync = 1'b0;
`endif
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = div_valid[c] && !m_pend[c];
        m_adv[c] = 0;
        if (m_sync) begin
          m_pos[c] = 0;
          if (m_pend[c]) begin
            m_div[c] = m_pdiv[c];
            m_pend[c] = 0;
          end
        end else if (en[c]) begin
          m_adv[c] = 1;
          m_pos[c] = m_pos[c] + 1;
          if (m_pos[c] == period(m_div[c])) begin
            m_pos[c] = 0;
            if (m_pend[c]) begin
              m_div[c] = m_pdiv[c];
              m_pend[c] = 0;
            end
          end
        end else if (m_pend[c]) begin
          m_pos[c] = 0;
          m_div[c] = m_pdiv[c];
          m_pend[c] = 0;
        end
        m_clk[c]  = m_pos[c] >= period(m_div[c]) / 2;
        m_tick[c] = m_adv[c] && (m_pos[c] == period(m_div[c]) / 2);
        if (m_acc[c]) begin
          m_pend[c] = 1;
          m_pdiv[c] = int'(div[c*CW +: CW]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("model_clk%0d", c), int'(clk_out[c]), int'(m_clk[c]));
        check($sformatf("model_tick%0d", c), int'(tick[c]), int'(m_tick[c]));
        check($sformatf("model_rdy%0d", c), int'(div_ready[c]), int'(!m_pend[c]));
      end
    end
  end

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[ch] && n < 400);
  endtask

  task automatic measure(input int ch, output int hi, output int lo);
    hi = 0;
    lo = 0;
    while (clk_out[ch] && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    while (!clk_out[ch] && lo < 400) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic load(input int ch, input int val);
    div[ch*CW +: CW] = CW'(val);
    div_valid[ch] = 1'b1;
    @(negedge clk);
    div_valid[ch] = 1'b0;
  endtask

  task automatic wait_ready(input int ch, output int n);
    n = 0;
    while (!div_ready[ch] && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n, hi, lo, first, second;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    en        = '0;
    div       = '0;
    div_valid = '0;
    sync      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_clk", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", int'(div_ready), 3);

    // Default ratio 50 on ch0.
    en[0] = 1'b1;
    wait_tick(0, n);
    check("t1_first_tick", n, 25);
    measure(0, hi, lo);
    check("t1_hi", hi, 25);
    check("t1_lo", lo, 25);

    // Mid-period load of 8 at cnt 10.
    repeat (35) @(negedge clk);
    load(0, 8);
    wait_ready(0, n);
    check("t2_ready_low", n, 39);
    wait_tick(0, n);
    check("t2_first_tick", n, 4);
    measure(0, hi, lo);
    check("t2_hi", hi, 4);
    check("t2_lo", lo, 4);

    // Ratios 0, 1 clamp to 2; 5 is 2 low / 3 high.
    load(0, 0);
    wait_ready(0, n);
    wait_tick(0, n);
    measure(0, hi, lo);
    check("t3_d0_hi", hi, 1);
    check("t3_d0_lo", lo, 1);
    load(0, 1);
    wait_ready(0, n);
    wait_tick(0, n);
    measure(0, hi, lo);
    check("t3_d1_hi", hi, 1);
    check("t3_d1_lo", lo, 1);
    load(0, 5);
    wait_ready(0, n);
    wait_tick(0, n);
    measure(0, hi, lo);
    check("t3_d5_hi", hi, 3);
    check("t3_d5_lo", lo, 2);

    // Freeze ch1 at cnt 30 for 100 cycles.
    en[1] = 1'b1;
    repeat (30) @(negedge clk);
    en[1] = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("t4_frozen_clk", int'(clk_out[1]), 1);
      check("t4_frozen_tick", int'(tick[1]), 0);
    end
    en[1] = 1'b1;
    wait_tick(1, n);
    check("t4_resume_tick", n, 45);
    en[1] = 1'b0;
    load(1, 6);
    @(negedge clk);
    check("t4_dis_load_clk", int'(clk_out[1]), 0);
    check("t4_dis_load_rdy", int'(div_ready[1]), 1);
    en[1] = 1'b1;
    wait_tick(1, n);
    check("t4_restart_tick", n, 3);
    measure(1, hi, lo);
    check("t4_d6_hi", hi, 3);
    check("t4_d6_lo", lo, 3);

    // Accept on the exact wrap cycle of ch0 (D=5).
    wait_tick(0, n);
    repeat (2) @(negedge clk);
    load(0, 10);
    check("t5_pending", int'(div_ready[0]), 0);
    wait_tick(0, n);
    check("t5_old_tick", n, 2);
    measure(0, hi, lo);
    check("t5_old_hi", hi, 3);
    check("t5_new_lo", lo, 5);
    measure(0, hi, lo);
    check("t5_new_hi", hi, 5);

    // Async reset while ch0 is high.
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_clk", int'(clk_out), 0);
    check("t5_async_tick", int'(tick), 0);
    check("t5_async_rdy", int'(div_ready), 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(0, n);
    check("t5_post_rst_tick", n, 25);
    measure(0, hi, lo);
    check("t5_post_rst_hi", hi, 25);
    check("t5_post_rst_lo", lo, 25);

`ifdef SOC_TICK_DIV_SYNC_EN
    load(1, 10);
    wait_ready(1, n);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("t6_sync_clk", int'(clk_out), 0);
    first = 0;
    second = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (tick == 2'b11) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
    end
    check("t6_first_align", first, 25);
    check("t6_second_align", second, 75);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
